// File: rtl/wb_csr_bridge_pkg.sv
// rtl/wb_csr_bridge_pkg.sv - shared CTI codes and FSM encoding for wb_csr_bridge
package wb_csr_bridge_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_ACK       = 2'd3
    } state_e;

endpackage

// File: rtl/wb_csr_bridge.sv
// rtl/wb_csr_bridge.sv - Wishbone slave to CSR bus bridge with fixed read latency
// Optional incrementing write bursts (one beat per cycle) when WB_CSR_BURST_EN is defined.
module wb_csr_bridge
    import wb_csr_bridge_pkg::*;
#(
    parameter int CSR_AW       = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [2:0]        wb_cti_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [31:0]       csr_do,
    input  logic [31:0]       csr_di
);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic [CSR_AW-1:0]   a_q, a_d;
    logic                we_q, we_d;
    logic [31:0]         do_q, do_d;
    logic                req;

`ifdef WB_CSR_BURST_EN
    // Set when the beat just accepted announced that another beat follows.
    logic                burst_q, burst_d;
`else
    logic                unused_cti;
    assign unused_cti = ^wb_cti_i;
`endif

    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0]};

    assign req = wb_cyc_i & wb_stb_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        we_d    = 1'b0;
        dat_d   = dat_q;
        a_d     = a_q;
        do_d    = do_q;
`ifdef WB_CSR_BURST_EN
        burst_d = burst_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    a_d  = wb_adr_i[CSR_AW+1:2];
                    do_d = wb_dat_i;
                    if (wb_we_i) begin
                        ack_d = 1'b1;
                        if (|wb_sel_i) begin
                            we_d    = 1'b1;
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_ACK;
                        end
`ifdef WB_CSR_BURST_EN
                        burst_d = (wb_cti_i == CTI_INCR);
`endif
                    end else begin
                        cnt_d   = 3'(READ_LATENCY);
                        state_d = ST_READ_WAIT;
                    end
                end
            end
            ST_WRITE: begin
`ifdef WB_CSR_BURST_EN
                if (burst_q && req && wb_we_i) begin
                    a_d     = wb_adr_i[CSR_AW+1:2];
                    do_d    = wb_dat_i;
                    we_d    = |wb_sel_i;
                    ack_d   = 1'b1;
                    burst_d = (wb_cti_i == CTI_INCR);
                end else begin
                    burst_d = 1'b0;
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_READ_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 3'd1) begin
                    dat_d   = csr_di;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // Request is not sampled here so a master still holding stb is serviced once.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            ack_q   <= 1'b0;
            dat_q   <= 32'd0;
            a_q     <= '0;
            we_q    <= 1'b0;
            do_q    <= 32'd0;
`ifdef WB_CSR_BURST_EN
            burst_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            a_q     <= a_d;
            we_q    <= we_d;
            do_q    <= do_d;
`ifdef WB_CSR_BURST_EN
            burst_q <= burst_d;
`endif
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign csr_a    = a_q;
    assign csr_we   = we_q;
    assign csr_do   = do_q;

endmodule

// File: tb/tb_wb_csr_bridge.sv
// tb/tb_wb_csr_bridge.sv - scoreboard bench for wb_csr_bridge (READ_LATENCY=2)
module tb_wb_csr_bridge;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [2:0]  wb_cti_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_do;
    logic [31:0] csr_di;
    logic [31:0] csr_pipe = '0;

    wb_csr_bridge #(.CSR_AW(14), .READ_LATENCY(2)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_cti_i(wb_cti_i),
        .wb_sel_i(wb_sel_i),
        .wb_we_i (wb_we_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i),
        .wb_ack_o(wb_ack_o),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_do  (csr_do),
        .csr_di  (csr_di)
    );

    always #5 sys_clk = ~sys_clk;

    // CSR peripheral with one register stage: data valid two cycles after csr_a.
    always @(posedge sys_clk)
        csr_pipe <= (csr_a == 14'd7) ? 32'h1234_5678 : (32'hA5A5_0000 | {18'd0, csr_a});
    assign csr_di = csr_pipe;

    int cyc_cnt = 0;
    always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {int cyc; bit rd; logic [31:0] dat;} ack_t;
    typedef struct {int cyc; logic [13:0] a; logic [31:0] d;} we_t;
    ack_t ack_q[$];
    we_t  we_q[$];
    ack_t ea;
    we_t  ew;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (wb_ack_o !== 1'b0) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", {31'd0, wb_ack_o}, 32'd0);
            end else begin
                ea = ack_q.pop_front();
                check("ack_cycle", cyc_cnt, ea.cyc);
                if (ea.rd) check("rd_data", wb_dat_o, ea.dat);
            end
        end
        if (csr_we !== 1'b0) begin
            if (we_q.size() == 0) begin
                check("unexpected_csr_we", {31'd0, csr_we}, 32'd0);
            end else begin
                ew = we_q.pop_front();
                check("we_cycle", cyc_cnt, ew.cyc);
                check("csr_a", {18'd0, csr_a}, {18'd0, ew.a});
                check("csr_do", csr_do, ew.d);
            end
        end
    end

    task automatic bus_idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'h0;
        wb_cti_i = 3'b000;
    endtask

    task automatic drive(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input logic [2:0] cti);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_cti_i = cti;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
    endtask

    task automatic wait_ack();
        bit got = 1'b0;
        repeat (20) begin
            if (!got) begin
                @(negedge sys_clk);
                got = wb_ack_o;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        bus_idle();
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic [2:0] cti, input logic [13:0] exp_a);
        int t0;
        @(negedge sys_clk);
        t0 = cyc_cnt;
        drive(adr, dat, sel, 1'b1, cti);
        ack_q.push_back('{t0 + 1, 1'b0, 32'h0});
        if (sel != 4'h0) we_q.push_back('{t0 + 1, exp_a, dat});
        wait_ack();
    endtask

    task automatic do_read(input logic [31:0] adr, input logic [31:0] exp);
        int t0;
        @(negedge sys_clk);
        t0 = cyc_cnt;
        drive(adr, 32'h0, 4'hF, 1'b0, 3'b000);
        ack_q.push_back('{t0 + 3, 1'b1, exp});
        wait_ack();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, {31'd0, wb_ack_o}, 32'd0);
        check({tag, "_dat_o"}, wb_dat_o, 32'd0);
        check({tag, "_csr_a"}, {18'd0, csr_a}, 32'd0);
        check({tag, "_csr_we"}, {31'd0, csr_we}, 32'd0);
        check({tag, "_csr_do"}, csr_do, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        bus_idle();
        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        sys_rst = 1'b0;

        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 14'd4);
        do_read (32'h0000_001C, 32'h1234_5678);
        do_write(32'hFFFF_0014, 32'hCAFE_F00D, 4'h3, 3'b010, 14'd5);
        do_write(32'h0000_0020, 32'h1111_2222, 4'h0, 3'b000, 14'd8);
        check("held_csr_a", {18'd0, csr_a}, 32'd8);
        check("held_csr_do", csr_do, 32'h1111_2222);
        do_read (32'h0000_000C, 32'hA5A5_0003);

        // Abort a read one cycle in; a write presented right after must see IDLE timing.
        @(negedge sys_clk);
        t0 = cyc_cnt;
        drive(32'h0000_0018, 32'h0, 4'hF, 1'b0, 3'b000);
        @(negedge sys_clk);
        bus_idle();
        @(negedge sys_clk);
        drive(32'h0000_0024, 32'h5555_AAAA, 4'hF, 1'b1, 3'b000);
        ack_q.push_back('{t0 + 3, 1'b0, 32'h0});
        we_q.push_back('{t0 + 3, 14'd9, 32'h5555_AAAA});
        wait_ack();
        check("abort_dat_held", wb_dat_o, 32'hA5A5_0003);

`ifdef WB_CSR_BURST_EN
        @(negedge sys_clk);
        t0 = cyc_cnt;
        drive(32'h0000_0020, 32'hB000_0000, 4'hF, 1'b1, 3'b010);
        ack_q.push_back('{t0 + 1, 1'b0, 32'h0});
        ack_q.push_back('{t0 + 2, 1'b0, 32'h0});
        ack_q.push_back('{t0 + 3, 1'b0, 32'h0});
        ack_q.push_back('{t0 + 4, 1'b0, 32'h0});
        we_q.push_back('{t0 + 1, 14'd8,  32'hB000_0000});
        we_q.push_back('{t0 + 2, 14'd9,  32'hB000_0001});
        we_q.push_back('{t0 + 3, 14'd10, 32'hB000_0002});
        we_q.push_back('{t0 + 4, 14'd11, 32'hB000_0003});
        @(negedge sys_clk);
        drive(32'h0000_0024, 32'hB000_0001, 4'hF, 1'b1, 3'b010);
        @(negedge sys_clk);
        drive(32'h0000_0028, 32'hB000_0002, 4'hF, 1'b1, 3'b010);
        @(negedge sys_clk);
        drive(32'h0000_002C, 32'hB000_0003, 4'hF, 1'b1, 3'b111);
        @(negedge sys_clk);
        bus_idle();
        do_read(32'h0000_001C, 32'h1234_5678);
`endif

        // Reset during the second cycle of a read: everything clears, no late ack.
        @(negedge sys_clk);
        drive(32'h0000_001C, 32'h0, 4'hF, 1'b0, 3'b000);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        bus_idle();
        @(negedge sys_clk);
        check_all_zero("midrst");
        sys_rst = 1'b0;
        repeat (6) @(negedge sys_clk);

        do_read(32'h0000_001C, 32'h1234_5678);
        repeat (3) @(negedge sys_clk);
        check("ack_queue_empty", ack_q.size(), 32'd0);
        check("we_queue_empty", we_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_csr_bridge.md
Name: wb_csr_bridge

Overview:
Wishbone slave that sits on one slave port of the system interconnect and converts 32-bit Wishbone cycles into the on-chip CSR bus that peripherals' control registers hang off.
- Registers address and write data, pulses the CSR write strobe, and waits a fixed CSR read latency before returning data with a registered ack.
- This is the standard downstream consumer of the interconnect's slave outputs.

Parameters:
CSR_AW, 14, CSR word-address width; csr_a = wb_adr_i[CSR_AW+1:2]
READ_LATENCY, 1, cycles from csr_a valid to csr_di valid; legal range 1..4

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  reset, synchronous, active-high
wb_adr_i  in  32  byte address; bits [CSR_AW+1:2] used, rest ignored
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, registered
wb_cti_i  in  3  cycle type identifier
wb_sel_i  in  4  byte selects; all-zero suppresses the write, otherwise full-word write
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_ack_o  out  1  registered ack
csr_a  out  CSR_AW  CSR word address, registered
csr_we  out  1  CSR write strobe, registered
csr_do  out  32  CSR write data, registered
csr_di  in  32  CSR read data

Behaviour:
- Clock and reset: single clock sys_clk; reset sys_rst is synchronous and active-high.
- Reset values: wb_ack_o=0, wb_dat_o=0, csr_a=0, csr_we=0, csr_do=0; FSM in IDLE; latency counter 0.
- Reset mid-transaction: outputs take reset values on the next edge; no csr_we pulse or ack is ever produced for a transaction interrupted by reset.
- FSM states: IDLE, WRITE, READ_WAIT, ACK.
- IDLE:
  - Request is cyc&stb sampled at edge N.
  - On request, register csr_a<=adr[CSR_AW+1:2] and csr_do<=wb_dat_i.
  - Write with sel≠0: csr_we<=1, wb_ack_o<=1, go to WRITE.
  - Write with sel=0: wb_ack_o<=1, csr_we stays 0, go to ACK.
  - Read: load counter with READ_LATENCY, go to READ_WAIT.
- WRITE: csr_we and wb_ack_o are both high during cycle N+1 (write ack latency 1). Next edge: csr_we<=0, wb_ack_o<=0, go to IDLE.
- Write commit: once sampled, a write is committed; dropping cyc during N+1 does not cancel the csr_we pulse.
- READ_WAIT:
  - Counter decrements each cycle.
  - At the edge where counter==1, capture wb_dat_o<=csr_di and set wb_ack_o<=1, then go to ACK.
  - The ack is therefore high during cycle N+READ_LATENCY+1.
  - If cyc deasserts in READ_WAIT: go to IDLE next edge with no ack; wb_dat_o is not updated.
- ACK: one cycle with wb_ack_o high, then wb_ack_o<=0 and go to IDLE. No request is sampled while ack is high, so a master holding stb is never double-serviced.
- Gap between classic transactions: minimum 1 idle cycle, i.e. one transaction per 2 cycles (writes) or per READ_LATENCY+2 cycles (reads).
- Held outputs: csr_a and csr_do hold their last values in IDLE; wb_dat_o holds the last read data until the next completed read.
- wb_sel_i: no partial-word semantics beyond the all-zero write suppression above.
- CTI: ignored unless WB_CSR_BURST_EN is defined.

Optional Feature:
WB_CSR_BURST_EN
- Defined:
  - In WRITE, if cyc&stb&we and wb_cti_i==3'b010 at the ack cycle, stay in WRITE and keep wb_ack_o high the next cycle.
  - Each streaming cycle registers adr/dat into csr_a/csr_do and pulses csr_we the following cycle, giving one beat acked per cycle.
  - The stream ends on the edge where an acked beat has cti==3'b111 or cyc is low; FSM then goes to IDLE.
  - Reads and cti==3'b000 behave as classic cycles.
- Undefined: CTI fully ignored; bursts degrade to classic cycles at 1 beat per 2 cycles.

Decomposition:
- Shared package: CTI constants (CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111) and FSM state encoding (2 bits).
- No sub-module. The read-latency counter is 3 bits and stays inline.

Test Plan:
- Classic write: adr=0x0000_0010, dat=0xDEADBEEF, sel=4'hF, stb at N → csr_a=4, csr_do=0xDEADBEEF, csr_we=1 and ack=1 in cycle N+1 only.
- Classic read with READ_LATENCY=2 and the CSR model returning 0x12345678 for address 7 → ack only at N+3, wb_dat_o=0x12345678; csr_we stays 0 throughout.
- Abort read: cyc drops at N+1 with READ_LATENCY=3 → no ack, wb_dat_o unchanged, FSM back in IDLE by N+2.
- Zero-sel write: sel=4'h0 → ack at N+1, csr_we never asserted.
- Reset at N+1 of a read → at N+2 all outputs 0, and no ack appears afterwards.
- Burst (WB_CSR_BURST_EN defined): 4-beat write, cti=010,010,010,111 to addresses 0x20..0x2C → ack high 4 consecutive cycles; csr_we high 4 consecutive cycles with csr_a=8,9,10,11; then IDLE.
